cfi_log_sequencer: RTL and testbench
====================================

# cfi_log_sequencer

Collects per-commit-port CFI commit logs from the commit-stage scanners, buffers them in order, and feeds them one at a time to a single downstream CFI checker. It holds one outstanding check at a time and raises commit back-pressure when the buffer cannot absorb a full commit group. A checker-reported violation is turned into a held exception until flush. It sits between the per-port `cfi_scanner` instances in the CFI stage and the checker, and drives the stage's `cfi_wait_o` / `cfi_fault_o`.

## Interface
- NR_COMMIT_PORTS, 2, number of commit ports / scanner logs per cycle
- DEPTH, 8, log FIFO entries; power of two, ≥ 2·NR_COMMIT_PORTS
- clk_i  in  1  clock
- rst_i  in  1  synchronous, active-high reset
- log_i  in  cfi_commit_log_t[NR_COMMIT_PORTS]  scanner logs
- log_valid_i  in  NR_COMMIT_PORTS  per-port push; already qualified as scanner_cfi & commit_ack
- flush_i  in  1  pipeline flush; clears buffer and fault
- chk_valid_o  out  1  head log presented to checker
- chk_log_o  out  cfi_commit_log_t  head log
- chk_ready_i  in  1  checker accepts head
- chk_resp_valid_i  in  1  checker verdict for the outstanding log
- chk_resp_fault_i  in  1  verdict is a violation
- chk_resp_tval_i  in  riscv::XLEN  faulting address
- wait_o  out  1  commit stall request
- fault_o  out  exception_t  CFI exception
- overflow_o  out  1  sticky protocol-violation flag

## Operation
- Push: all set `log_valid_i` bits are enqueued in one cycle, lowest port index first. Holes in the valid vector are compacted.
- Pop: occurs on `chk_valid_o & chk_ready_i`.
- `count` is `$clog2(DEPTH)+1` bits wide. Pointers are `$clog2(DEPTH)` bits and wrap modulo DEPTH.
- Next count = count + popcount(pushes) − pop. Push and pop in the same cycle are both legal.
- `wait_o = (DEPTH − count < NR_COMMIT_PORTS) | (state != IDLE && state != BUSY)`.
- Upstream must not push while `wait_o` is high. Any push that would exceed DEPTH is dropped and sets `overflow_o`, which is cleared only by reset.
- State IDLE:
  - `chk_valid_o = (count != 0)`.
  - On handshake, go to BUSY.
- State BUSY:
  - `chk_valid_o = 0`.
  - On `chk_resp_valid_i & !fault`, go to IDLE.
  - On `chk_resp_valid_i & fault`, go to FAULT and latch tval.
- State FAULT:
  - `fault_o.valid = 1`, `fault_o.cause = CFI_FAULT_CAUSE`, `fault_o.tval = latched tval`.
  - `chk_valid_o = 0`.
  - Pushes are still accepted if room exists.
  - Hold until `flush_i`.
- State DRAIN: entered when `flush_i` arrives in BUSY.
  - Waits for the outstanding response and discards it (no fault).
  - Goes to IDLE on `chk_resp_valid_i`.
- `flush_i` in any state empties the FIFO (count = 0, pointers reset) and clears `fault_o`.
  - Pushes arriving in the flush cycle are discarded.
  - Next state: DRAIN if in BUSY, else IDLE.
- `chk_resp_valid_i` in IDLE or FAULT is ignored.

## Timing
- Reset values:
  - state IDLE, count 0, pointers 0.
  - `chk_valid_o` 0, `chk_log_o` 0.
  - `wait_o` 0, `fault_o` all zero, `overflow_o` 0.
- Push at cycle N makes the head visible at N+1. There is no combinational path from `log_*` to `chk_*`.
- `wait_o` is derived from registered count/state only. It reflects the pushes of cycle N at N+1.
- A faulting response at cycle N gives `fault_o.valid` = 1 at N+1.
- An IDLE handshake at N gives BUSY at N+1. The next head can issue no earlier than the cycle after a clean response, so there is one bubble per check minimum.
- `chk_log_o` is stable while `chk_valid_o` is high and not yet accepted.

## Structure
- Add to `cfi_pkg`:
  - `cfi_seq_state_e` (IDLE, BUSY, FAULT, DRAIN).
  - `CFI_FAULT_CAUSE` (XLEN-wide constant).
  - Reuse `cfi_commit_log_t`.
- Sub-module `cfi_log_fifo`: multi-push (NR_COMMIT_PORTS), single-pop, with flush, count, and overflow outputs. The sequencer FSM, wait, and fault logic stay in `cfi_log_sequencer`.

## Test plan
- Reset, then 2-port push of logs A,B at cycle 1 with `chk_ready_i` = 1 → A presented at cycle 2; BUSY; clean response at 4 → B presented at 5; count 2→1→0.
- `log_valid_i` = 2'b10 with log C → C enqueued as a single entry (compaction); count = 1; head = C.
- Checker stalled with DEPTH = 8 and seven entries → `wait_o` = 1 once count ≥ 7; forced 2-push at count 7 → one entry dropped, `overflow_o` = 1 and stays 1.
- Faulting response with tval 0x8000_1234 → next cycle `fault_o.valid` = 1, `cause` = CFI_FAULT_CAUSE, `tval` = 0x8000_1234; `chk_valid_o` = 0 and `wait_o` = 1 until `flush_i`, then count 0 and IDLE.
- `flush_i` while BUSY with 3 queued → count 0; DRAIN; a faulting response arriving afterwards produces no `fault_o`; IDLE follows the response.
- Same-cycle push of 2 and pop at count 4 → count 5; FIFO order preserved across pointer wrap (≥ 3·DEPTH entries streamed in order).

Source files
------------

// File: rtl/cfi_pkg.sv
// cfi_pkg: shared types/constants for the CFI log sequencer (XLEN, states, commit log, exception)
package cfi_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] CFI_FAULT_CAUSE = XLEN'(18);
  typedef enum logic [1:0] {IDLE, BUSY, FAULT, DRAIN} cfi_seq_state_e;
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] target;
    logic [2:0]      kind;
  } cfi_commit_log_t;
  typedef struct packed {
    logic [XLEN-1:0] cause;
    logic [XLEN-1:0] tval;
    logic            valid;
  } exception_t;
endpackage

// File: rtl/cfi_log_fifo.sv
// cfi_log_fifo: compacting multi-push single-pop log FIFO; ports clk/rst/flush, push_data/push_valid in, pop in, head/count/overflow out
module cfi_log_fifo
  import cfi_pkg::*;
#(
  parameter int NR    = 2,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  cfi_commit_log_t            push_data [NR],
  input  logic [NR-1:0]              push_valid,
  input  logic                       pop,
  output cfi_commit_log_t            head,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  cfi_commit_log_t mem [DEPTH];
  logic [PW-1:0] wptr, rptr;
  logic [PW-1:0] slot [NR];
  logic [NR-1:0] acc;
  logic [CW-1:0] n, room;
  logic drop;
  assign room = CW'(DEPTH) - count;
  always_comb begin
    n = '0;
    drop = 1'b0;
    acc = '0;
    for (int i = 0; i < NR; i++) begin
      slot[i] = wptr + n[PW-1:0];
      acc[i] = push_valid[i] && (n < room);
      drop = drop | (push_valid[i] && (n >= room));
      n = n + CW'(acc[i]);
    end
  end
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wptr <= '0;
      rptr <= '0;
      count <= '0;
    end else begin
      wptr <= wptr + n[PW-1:0];
      rptr <= rptr + PW'(pop);
      count <= count + n - CW'(pop);
    end
  end
  always_ff @(posedge clk)
    for (int i = 0; i < NR; i++)
      if (acc[i] && !flush) mem[slot[i]] <= push_data[i];
  always_ff @(posedge clk) overflow <= rst ? 1'b0 : overflow | (drop & ~flush);
  assign head = (count != '0) ? mem[rptr] : '0;
endmodule

// File: rtl/cfi_log_sequencer.sv
// cfi_log_sequencer: buffers scanner logs and issues them one at a time to the CFI checker; log_i/log_valid_i in, chk_* handshake, wait_o/fault_o/overflow_o out
module cfi_log_sequencer
  import cfi_pkg::*;
#(
  parameter int NR_COMMIT_PORTS = 2,
  parameter int DEPTH           = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  cfi_commit_log_t            log_i [NR_COMMIT_PORTS],
  input  logic [NR_COMMIT_PORTS-1:0] log_valid_i,
  input  logic                       flush_i,
  output logic                       chk_valid_o,
  output cfi_commit_log_t            chk_log_o,
  input  logic                       chk_ready_i,
  input  logic                       chk_resp_valid_i,
  input  logic                       chk_resp_fault_i,
  input  logic [XLEN-1:0]            chk_resp_tval_i,
  output logic                       wait_o,
  output exception_t                 fault_o,
  output logic                       overflow_o
);
  localparam int CW = $clog2(DEPTH) + 1;
  cfi_seq_state_e state_q, state_d;
  logic [XLEN-1:0] tval_q, tval_d;
  logic [CW-1:0] count;
  logic pop;
  assign pop = chk_valid_o & chk_ready_i;
  cfi_log_fifo #(.NR(NR_COMMIT_PORTS), .DEPTH(DEPTH)) u_fifo (
    .clk       (clk_i),
    .rst       (rst_i),
    .flush     (flush_i),
    .push_data (log_i),
    .push_valid(log_valid_i),
    .pop       (pop),
    .head      (chk_log_o),
    .count     (count),
    .overflow  (overflow_o)
  );
  always_comb begin
    state_d = state_q;
    tval_d = tval_q;
    case (state_q)
      IDLE:    state_d = pop ? BUSY : IDLE;
      BUSY: begin
        state_d = chk_resp_valid_i ? (chk_resp_fault_i ? FAULT : IDLE) : BUSY;
        tval_d = (chk_resp_valid_i && chk_resp_fault_i) ? chk_resp_tval_i : tval_q;
      end
      DRAIN:   state_d = chk_resp_valid_i ? IDLE : DRAIN;
      default: state_d = FAULT;
    endcase
    if (flush_i) state_d = (state_q == BUSY) ? DRAIN : IDLE;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      tval_q <= '0;
    end else begin
      state_q <= state_d;
      tval_q <= tval_d;
    end
  end
  assign chk_valid_o = (state_q == IDLE) && (count != '0);
  assign wait_o = ((CW'(DEPTH) - count) < CW'(NR_COMMIT_PORTS)) || (state_q == FAULT) || (state_q == DRAIN);
  assign fault_o = (state_q == FAULT) ? '{cause: CFI_FAULT_CAUSE, tval: tval_q, valid: 1'b1} : '0;
endmodule

// File: tb/tb_cfi_log_sequencer.sv
// tb_cfi_log_sequencer: directed + randomized bench against a queue-based reference model
module tb_cfi_log_sequencer;
  import cfi_pkg::*;
  localparam int NR = 2;
  localparam int DEPTH = 8;
  logic clk = 1'b0;
  logic rst;
  cfi_commit_log_t lg [NR];
  logic [NR-1:0] vld;
  logic fl, rdy, rv, rf;
  logic [XLEN-1:0] tv;
  logic chk_valid, wait_s, ovf_s;
  cfi_commit_log_t chk_log;
  exception_t fault;
  int checks = 0;
  int errors = 0;
  cfi_commit_log_t q[$];
  int ms;
  logic m_ovf;
  logic [XLEN-1:0] m_tval;
  cfi_commit_log_t a, b, c;
  always #5 clk = ~clk;
  cfi_log_sequencer #(.NR_COMMIT_PORTS(NR), .DEPTH(DEPTH)) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .log_i           (lg),
    .log_valid_i     (vld),
    .flush_i         (fl),
    .chk_valid_o     (chk_valid),
    .chk_log_o       (chk_log),
    .chk_ready_i     (rdy),
    .chk_resp_valid_i(rv),
    .chk_resp_fault_i(rf),
    .chk_resp_tval_i (tv),
    .wait_o          (wait_s),
    .fault_o         (fault),
    .overflow_o      (ovf_s)
  );
  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask
  function automatic logic exp_valid();
    return ms == 0 && q.size() > 0;
  endfunction
  function automatic logic exp_wait();
    return (DEPTH - q.size() < NR) || ms == 2 || ms == 3;
  endfunction
  task automatic compare_all();
    exception_t ef;
    cfi_commit_log_t eh;
    ef = (ms == 2) ? '{cause: CFI_FAULT_CAUSE, tval: m_tval, valid: 1'b1} : '0;
    eh = q.size() > 0 ? q[0] : '0;
    check("chk_valid", 128'(chk_valid), 128'(exp_valid()));
    check("chk_log", 128'(chk_log), 128'(eh));
    check("wait", 128'(wait_s), 128'(exp_wait()));
    check("fault", 128'(fault), 128'(ef));
    check("overflow", 128'(ovf_s), 128'(m_ovf));
  endtask
  task automatic model_step();
    logic pop;
    int room, acc;
    pop = exp_valid() && rdy;
    if (fl) begin
      q.delete();
      ms = (ms == 1) ? 3 : 0;
    end else begin
      room = DEPTH - q.size();
      acc = 0;
      if (pop) void'(q.pop_front());
      for (int i = 0; i < NR; i++)
        if (vld[i]) begin
          if (acc < room) begin
            q.push_back(lg[i]);
            acc++;
          end else m_ovf = 1'b1;
        end
      if (ms == 0 && pop) ms = 1;
      else if (ms == 1 && rv) begin
        ms = rf ? 2 : 0;
        if (rf) m_tval = tv;
      end else if (ms == 3 && rv) ms = 0;
    end
  endtask
  task automatic cyc(input logic [NR-1:0] v, input logic r, input logic resp, input logic f,
                     input logic [XLEN-1:0] t, input logic flush);
    @(negedge clk);
    for (int i = 0; i < NR; i++) lg[i] = '{pc: $urandom, target: $urandom, kind: 3'($urandom)};
    vld = v;
    rdy = r;
    rv = resp;
    rf = f;
    tv = t;
    fl = flush;
    #1;
    compare_all();
    model_step();
    @(posedge clk);
    #1;
  endtask
  initial begin
    rst = 1'b1;
    vld = '0;
    fl = 1'b0;
    rdy = 1'b0;
    rv = 1'b0;
    rf = 1'b0;
    tv = '0;
    for (int i = 0; i < NR; i++) lg[i] = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    q.delete();
    ms = 0;
    m_ovf = 1'b0;
    m_tval = '0;
    check("rst_chk_valid", 128'(chk_valid), 128'(0));
    check("rst_chk_log", 128'(chk_log), 128'(0));
    check("rst_wait", 128'(wait_s), 128'(0));
    check("rst_fault", 128'(fault), 128'(0));
    check("rst_overflow", 128'(ovf_s), 128'(0));
    cyc(2'b11, 1, 0, 0, 0, 0);
    a = lg[0];
    b = lg[1];
    check("head_a", 128'(chk_log), 128'(a));
    check("valid_a", 128'(chk_valid), 128'(1));
    cyc(2'b00, 1, 0, 0, 0, 0);
    check("busy_no_valid", 128'(chk_valid), 128'(0));
    cyc(2'b00, 1, 0, 0, 0, 0);
    cyc(2'b00, 1, 1, 0, 0, 0);
    check("head_b", 128'(chk_log), 128'(b));
    cyc(2'b00, 1, 0, 0, 0, 0);
    cyc(2'b00, 0, 1, 0, 0, 0);
    cyc(2'b10, 0, 0, 0, 0, 0);
    c = lg[1];
    check("compact_c", 128'(chk_log), 128'(c));
    cyc(2'b00, 1, 0, 0, 0, 0);
    cyc(2'b00, 0, 1, 0, 0, 0);
    cyc(2'b11, 0, 0, 0, 0, 0);
    cyc(2'b11, 0, 0, 0, 0, 0);
    cyc(2'b11, 0, 0, 0, 0, 0);
    cyc(2'b01, 0, 0, 0, 0, 0);
    check("wait_at_7", 128'(wait_s), 128'(1));
    cyc(2'b11, 0, 0, 0, 0, 0);
    check("overflow_set", 128'(ovf_s), 128'(1));
    cyc(2'b00, 1, 0, 0, 0, 0);
    cyc(2'b00, 0, 1, 1, 32'h8000_1234, 0);
    check("fault_valid", 128'(fault.valid), 128'(1));
    check("fault_cause", 128'(fault.cause), 128'(CFI_FAULT_CAUSE));
    check("fault_tval", 128'(fault.tval), 128'(32'h8000_1234));
    cyc(2'b00, 1, 1, 0, 0, 0);
    check("fault_hold_wait", 128'(wait_s), 128'(1));
    check("fault_hold_valid", 128'(chk_valid), 128'(0));
    cyc(2'b00, 0, 0, 0, 0, 1);
    check("flush_fault_clr", 128'(fault.valid), 128'(0));
    check("flush_wait_clr", 128'(wait_s), 128'(0));
    check("overflow_sticky", 128'(ovf_s), 128'(1));
    cyc(2'b11, 0, 0, 0, 0, 0);
    cyc(2'b11, 0, 0, 0, 0, 0);
    cyc(2'b00, 1, 0, 0, 0, 0);
    cyc(2'b00, 0, 0, 0, 0, 1);
    check("drain_empty", 128'(chk_valid), 128'(0));
    check("drain_wait", 128'(wait_s), 128'(1));
    cyc(2'b00, 0, 1, 1, 32'hdead_beef, 0);
    check("drain_no_fault", 128'(fault.valid), 128'(0));
    check("drain_to_idle", 128'(wait_s), 128'(0));
    cyc(2'b11, 0, 0, 0, 0, 0);
    cyc(2'b11, 0, 0, 0, 0, 0);
    cyc(2'b11, 1, 0, 0, 0, 0);
    cyc(2'b00, 0, 1, 0, 0, 0);
    for (int k = 0; k < 4000; k++) begin
      logic [NR-1:0] v;
      v = exp_wait() ? (($urandom_range(0, 63) == 0) ? NR'($urandom) : '0) : NR'($urandom);
      cyc(v, $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0,
          $urandom, $urandom_range(0, 19) == 0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
